alu_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one combinational `alu` instance between two requesters.
- Each requester submits an operation over a valid/ready request channel and receives its result over a valid/ready response channel.
- The block registers the operands, drives the ALU select and operand inputs, captures the result and returns it to the owning requester.
- It sits between client blocks and the `alu` instance; the ALU itself stays a separate module wired through the alu_* ports.

---
 rtl/alu_arbiter.sv | 92 +++++++++
 tb/tb_alu_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external ALU between two requesters
module alu_arbiter #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_x,
    input  logic [W-1:0]   req0_y,
    input  logic [1:0]     req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_x,
    input  logic [W-1:0]   req1_y,
    input  logic [1:0]     req1_op,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [2*W-1:0] rsp_z,
    output logic [W-1:0]   alu_x,
    output logic [W-1:0]   alu_y,
    output logic [1:0]     alu_s,
    input  logic [2*W-1:0] alu_z,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t           state_q, state_d;
    logic             prio_q, prio_d, owner_q, owner_d;
    logic [W-1:0]     x_q, x_d, y_q, y_d;
    logic [1:0]       op_q, op_d;
    logic [2*W-1:0]   z_q, z_d;
    logic             any, gnt, hs, rsp_hs;
    always_comb begin
        any        = req0_valid | req1_valid;
        gnt        = (req0_valid & req1_valid) ? prio_q : req1_valid;
        req0_ready = !rst && state_q == IDLE && any && !gnt;
        req1_ready = !rst && state_q == IDLE && any && gnt;
        hs         = req0_ready | req1_ready;
        rsp0_valid = state_q == RESP && !owner_q;
        rsp1_valid = state_q == RESP && owner_q;
        rsp_hs     = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
        state_d    = state_q;
        prio_d     = prio_q;
        owner_d    = owner_q;
        x_d        = x_q;
        y_d        = y_q;
        op_d       = op_q;
        z_d        = z_q;
        case (state_q)
            IDLE: if (hs) begin
                owner_d = gnt;
                prio_d  = !gnt;
                x_d     = gnt ? req1_x : req0_x;
                y_d     = gnt ? req1_y : req0_y;
                op_d    = gnt ? req1_op : req0_op;
                state_d = EXEC;
            end
            EXEC: begin
                z_d     = alu_z;
                state_d = RESP;
            end
            RESP:    state_d = rsp_hs ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            x_q     <= x_d;
            y_q     <= y_d;
            op_q    <= op_d;
            z_q     <= z_d;
        end
    end
    assign rsp_z = z_q;
    assign alu_x = x_q;
    assign alu_y = y_q;
    assign alu_s = op_q;
    assign busy  = state_q != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed plus random checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
    localparam int W = 4;
    logic clk = 0, rst = 1;
    logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
    logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [W-1:0] req0_x = 0, req0_y = 0, req1_x = 0, req1_y = 0, alu_x, alu_y;
    logic [1:0] req0_op = 0, req1_op = 0, alu_s;
    logic [2*W-1:0] rsp_z, alu_z;
    int checks = 0, errors = 0;
    int ph = 0, prio = 0, own = 0, mx = 0, my = 0, mop = 0, mz = 0;
    bit acc0, acc1, keep_valid;
    int gnt_log[$], rsp_own[$], rsp_val[$];
    int base;

    always #5 clk = ~clk;

    // stand-in for the external ALU
    always_comb begin
        unique case (alu_s)
            2'd0: alu_z = {4'b0, alu_x} + {4'b0, alu_y};
            2'd1: alu_z = {4'b0, alu_x} - {4'b0, alu_y};
            2'd2: alu_z = alu_x * alu_y;
            default: alu_z = '0;
        endcase
    end

    alu_arbiter #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_z(rsp_z), .alu_x(alu_x), .alu_y(alu_y), .alu_s(alu_s), .alu_z(alu_z), .busy(busy)
    );

    function automatic int ref_z(int x, int y, int op);
        case (op)
            0: return x + y;
            1: return (x - y + 256) % 256;
            2: return x * y;
            default: return 0;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int g;
        bit any;
        @(negedge clk);
        any = req0_valid || req1_valid;
        g = (req0_valid && req1_valid) ? prio : (req1_valid ? 1 : 0);
        acc0 = ph == 0 && any && g == 0;
        acc1 = ph == 0 && any && g == 1;
        chk("req0_ready", req0_ready, acc0);
        chk("req1_ready", req1_ready, acc1);
        chk("rsp0_valid", rsp0_valid, ph == 2 && own == 0);
        chk("rsp1_valid", rsp1_valid, ph == 2 && own == 1);
        chk("busy", busy, ph != 0);
        if (ph == 2) chk("rsp_z", rsp_z, mz);
        if (ph != 0) begin
            chk("alu_x", alu_x, mx);
            chk("alu_y", alu_y, my);
            chk("alu_s", alu_s, mop);
        end
        if (ph == 0) begin
            if (any) begin
                own  = g;
                mx   = g ? req1_x : req0_x;
                my   = g ? req1_y : req0_y;
                mop  = g ? req1_op : req0_op;
                prio = 1 - g;
                gnt_log.push_back(g);
                ph = 1;
            end
        end else if (ph == 1) begin
            mz = ref_z(mx, my, mop);
            ph = 2;
        end else if (own == 0 ? rsp0_ready : rsp1_ready) begin
            rsp_own.push_back(own);
            rsp_val.push_back(mz);
            ph = 0;
        end
        @(posedge clk);
        #1;
        if (acc0 && !keep_valid) req0_valid = 0;
        if (acc1 && !keep_valid) req1_valid = 0;
    endtask

    task automatic run(int n);
        repeat (n) cycle();
    endtask

    initial begin
        // reset state, with requests present to show ready is forced low
        req0_valid = 1; req1_valid = 1;
        #3;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_z", rsp_z, 0);
        chk("rst_alu_x", alu_x, 0);
        req0_valid = 0; req1_valid = 0;
        @(posedge clk); #1 rst = 0;

        // contention at reset priority
        rsp0_ready = 1; rsp1_ready = 1;
        req0_x = 3; req0_y = 5; req0_op = 1; req0_valid = 1;
        req1_x = 4; req1_y = 7; req1_op = 2; req1_valid = 1;
        base = rsp_own.size();
        run(6);
        chk("cont_n", rsp_own.size() - base, 2);
        chk("cont_own0", rsp_own[base], 0);
        chk("cont_z0", rsp_val[base], 8'hFE);
        chk("cont_own1", rsp_own[base+1], 1);
        chk("cont_z1", rsp_val[base+1], 28);

        // fairness with both requesters holding valid
        keep_valid = 1;
        req0_x = 1; req0_y = 1; req0_op = 0; req0_valid = 1;
        req1_x = 1; req1_y = 1; req1_op = 0; req1_valid = 1;
        base = gnt_log.size();
        run(12);
        req0_valid = 0; req1_valid = 0; keep_valid = 0;
        chk("fair_n", gnt_log.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk("fair_gnt", gnt_log[base+i], i % 2);
            chk("fair_z", rsp_val[rsp_val.size()-4+i], 2);
        end

        // single add
        req0_x = 4; req0_y = 5; req0_op = 0; req0_valid = 1;
        #1 chk("add_ready", req0_ready, 1);
        cycle();
        chk("add_busy_exec", busy, 1);
        cycle();
        chk("add_rsp0_valid", rsp0_valid, 1);
        chk("add_rsp_z", rsp_z, 9);
        chk("add_rsp1_valid", rsp1_valid, 0);
        cycle();
        chk("add_idle", busy, 0);

        // backpressure on requester 1 while requester 0 waits
        rsp1_ready = 0;
        req1_x = 10; req1_y = 2; req1_op = 1; req1_valid = 1;
        req0_x = 2; req0_y = 3; req0_op = 0; req0_valid = 1;
        run(2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp1_valid", rsp1_valid, 1);
            chk("bp_rsp_z", rsp_z, 8);
            chk("bp_req0_ready", req0_ready, 0);
            cycle();
        end
        rsp1_ready = 1;
        cycle();
        chk("bp_idle", busy, 0);
        chk("bp_next_ready", req0_ready, 1);
        run(3);
        chk("bp_req0_z", rsp_val[rsp_val.size()-1], 5);

        // zero op
        req0_x = 4; req0_y = 7; req0_op = 3; req0_valid = 1;
        run(3);
        chk("zero_z", rsp_val[rsp_val.size()-1], 0);

        // reset in the middle of an operation
        req0_x = 5; req0_y = 6; req0_op = 2; req0_valid = 1;
        cycle();
        chk("mid_exec", busy, 1);
        req0_valid = 1; req1_valid = 1;
        #2 rst = 1;
        #1;
        chk("mid_req0_ready", req0_ready, 0);
        chk("mid_req1_ready", req1_ready, 0);
        chk("mid_rsp0_valid", rsp0_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_rsp_z", rsp_z, 0);
        chk("mid_alu_x", alu_x, 0);
        chk("mid_alu_s", alu_s, 0);
        ph = 0; prio = 0; mx = 0; my = 0; mop = 0; mz = 0;
        req0_valid = 0; req1_valid = 0;
        @(posedge clk); #1 rst = 0;
        base = rsp_own.size();
        run(3);
        chk("post_rst_no_rsp", rsp_own.size() - base, 0);
        req0_x = 6; req0_y = 2; req0_op = 1; req0_valid = 1;
        req1_x = 1; req1_y = 2; req1_op = 0; req1_valid = 1;
        #1 chk("post_rst_prio", req0_ready, 1);
        run(6);
        chk("post_rst_z0", rsp_val[base], 4);
        chk("post_rst_z1", rsp_val[base+1], 3);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid && $urandom_range(2) == 0) begin
                req0_x = W'($urandom); req0_y = W'($urandom); req0_op = 2'($urandom); req0_valid = 1;
            end
            if (!req1_valid && $urandom_range(2) == 0) begin
                req1_x = W'($urandom); req1_y = W'($urandom); req1_op = 2'($urandom); req1_valid = 1;
            end
            rsp0_ready = 1'($urandom);
            rsp1_ready = 1'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
